// File: rtl/alu_seq_ctrl_if.sv
// Bus bundle between the fetch/decode/execute sequencer and its memories/ALU.
interface alu_seq_ctrl_if #(parameter int AW = 4);
    logic          start;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [7:0]    imem_data;
    logic          dmem_rd;
    logic          dmem_wr;
    logic [AW-1:0] dmem_addr;
    logic [2:0]    dmem_wdata;
    logic          dmem_ack;
    logic [2:0]    dmem_rdata;
    logic [6:0]    alu_op;
    logic [2:0]    alu_r1;
    logic [2:0]    alu_r2;
    logic [2:0]    alu_m;
    logic [2:0]    alu_out;
    logic [AW-1:0] pc;
    logic          halted;
    logic          illegal;

    modport master (
        input  start, imem_ack, imem_data, dmem_ack, dmem_rdata, alu_out,
        output imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
               alu_op, alu_r1, alu_r2, alu_m, pc, halted, illegal
    );

    modport slave (
        output start, imem_ack, imem_data, dmem_ack, dmem_rdata, alu_out,
        input  imem_req, imem_addr, dmem_rd, dmem_wr, dmem_addr, dmem_wdata,
               alu_op, alu_r1, alu_r2, alu_m, pc, halted, illegal
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 3-bit accumulator ALU; owns PC, IR, ACC, OPND.
module alu_seq_ctrl #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEMRD  = 3'd3;
    localparam logic [2:0] S_MEMWR  = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    logic [2:0]    state;
    logic [AW-1:0] pc;
    logic [7:0]    ir;
    logic [2:0]    acc;
    logic [2:0]    opnd;
    logic          illegal;
    logic [3:0]    op;
    logic [AW-1:0] addr;

    assign op   = ir[7:4];
    assign addr = ir[AW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            acc     <= '0;
            opnd    <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        ir    <= bus.imem_data;
                        pc    <= pc + AW'(1);
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op)
                        4'h0, 4'h1, 4'h2, 4'h3: state <= S_EXEC;
                        4'h5, 4'h7:             state <= S_MEMRD;
                        4'h6:                   state <= S_MEMWR;
                        4'h4:                   state <= S_FETCH;
                        4'h8: begin
                            pc    <= addr;
                            state <= S_FETCH;
                        end
                        4'h9: begin
                            if (acc[2]) pc <= addr;
                            state <= S_FETCH;
                        end
                        4'hF:                   state <= S_HALT;
                        default: begin
                            illegal <= 1'b1;
                            state   <= S_HALT;
                        end
                    endcase
                end
                S_MEMRD: begin
                    if (bus.dmem_ack) begin
                        opnd  <= bus.dmem_rdata;
                        state <= S_EXEC;
                    end
                end
                S_MEMWR: begin
                    if (bus.dmem_ack) state <= S_FETCH;
                end
                // ALU registers its result at the end of EXEC, so ACC picks it up in WB.
                S_EXEC: state <= S_WB;
                S_WB: begin
                    acc   <= bus.alu_out;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    if (bus.start) begin
                        illegal <= 1'b0;
                        pc      <= '0;
                        state   <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Requests decode straight from state so an async reset drops them immediately.
    assign bus.imem_req   = (state == S_FETCH);
    assign bus.imem_addr  = pc;
    assign bus.dmem_rd    = (state == S_MEMRD);
    assign bus.dmem_wr    = (state == S_MEMWR);
    assign bus.dmem_addr  = addr;
    assign bus.dmem_wdata = acc;
    assign bus.alu_op     = (state == S_EXEC) ? {3'b000, op} : 7'b0000000;
    assign bus.alu_r1     = acc;
    assign bus.alu_r2     = opnd;
    assign bus.alu_m      = opnd;
    assign bus.pc         = pc;
    assign bus.halted     = (state == S_HALT);
    assign bus.illegal    = illegal;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Fetch/decode/execute sequencer for the 3-bit accumulator ALU. Fetches 8-bit instructions over a req/ack instruction port, fetches or stores operands over a req/ack data port, issues the 7-bit `alu_op` to the registered ALU, and writes the ALU result back into its internal accumulator. It sits between the instruction/data memories and the ALU, and owns PC, IR, ACC and the operand register.

## Interface
- `AW`, 4, instruction and data address width; PC wraps modulo 2^AW
- `clk`  in  1  rising-edge clock, shared with the ALU
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  leave IDLE or HALT; PC is cleared to 0 on the transition
- `imem_req`  out  1  instruction fetch request
- `imem_addr`  out  AW  fetch address, equal to PC
- `imem_ack`  in  1  fetch complete; `imem_data` is valid in the same cycle
- `imem_data`  in  8  instruction: {op[3:0], addr[3:0]} (addr is the low AW bits)
- `dmem_rd`  out  1  operand read request
- `dmem_wr`  out  1  store request
- `dmem_addr`  out  AW  operand/store address, equal to IR addr
- `dmem_wdata`  out  3  store data, equal to ACC
- `dmem_ack`  in  1  data access complete; `dmem_rdata` is valid in the same cycle
- `dmem_rdata`  in  3  read data
- `alu_op`  out  7  ALU opcode, {3'b000, op}
- `alu_r1`  out  3  equal to ACC
- `alu_r2`  out  3  equal to OPND
- `alu_m`  out  3  equal to OPND
- `alu_out`  in  3  registered ALU result
- `pc`  out  AW  current PC
- `halted`  out  1  in HALT
- `illegal`  out  1  sticky illegal-opcode flag; cleared by `start` or `rst`

## Operation
- States: IDLE, FETCH, DECODE, MEMRD, MEMWR, EXEC, WB, HALT.
- IDLE: when `start`=1, set PC←0 and go to FETCH.
- FETCH: hold `imem_req`=1. On `imem_ack`, set IR←`imem_data` and PC←PC+1 (wraps), then go to DECODE.
- DECODE, by op:
  - 0 CLA, 1 COM, 2 SHR, 3 CSL go to EXEC.
  - 5 ADD and 7 LDA go to MEMRD.
  - 6 STA goes to MEMWR.
  - 8 JMP: PC←addr, go to FETCH.
  - 9 BAN: if ACC[2]=1 then PC←addr; go to FETCH.
  - 4 NOP goes to FETCH.
  - F HLT goes to HALT.
  - A–E: set `illegal`←1 and go to HALT.
- MEMRD: hold `dmem_rd`=1. On `dmem_ack`, set OPND←`dmem_rdata`, then go to EXEC.
- MEMWR: hold `dmem_wr`=1 with `dmem_wdata`=ACC. On `dmem_ack`, go to FETCH. ACC is unchanged.
- EXEC: drive `alu_op`={3'b000,op} for exactly one cycle; the ALU registers its result at the end of this cycle. Then go to WB.
- WB: ACC←`alu_out`, then go to FETCH.
- Outside EXEC, `alu_op`=7'b0000000.
- HALT: `halted`=1. On `start`, clear `illegal`, set PC←0 and go to FETCH.
- `start` is ignored in all other states.
- Arithmetic: all ALU results are 3-bit, with carry/overflow discarded (modulo 8). PC increment is modulo 2^AW.
- `dmem_rd` and `dmem_wr` are never both high, and never high together with `imem_req`.

## Timing
- Reset values: state=IDLE; PC, IR, ACC, OPND = 0; `imem_req`, `dmem_rd`, `dmem_wr`, `halted`, `illegal` = 0; `alu_op`=0.
- Reset takes effect asynchronously. Asserting `rst` mid-transaction drops any pending request in the same cycle, with no handshake completion.
- Requests are level signals held until ack. An ack sampled in the first request cycle is legal, giving zero wait states.
- An ack received while no request is pending is ignored.
- Minimum cycles per instruction (start of FETCH to start of next FETCH), with zero-wait acks:
  - CLA/COM/SHR/CSL: 4 (FETCH, DECODE, EXEC, WB).
  - ADD/LDA: 5.
  - STA: 3.
  - JMP/BAN/NOP: 2.
- Each wait cycle on an ack adds one cycle.
- Branch and jump targets take effect on the next FETCH; there is no delay slot.
- ACC updates only at the end of WB. `alu_r1` reflects the new value from the following cycle.

## Test plan
- Reset with `start`=0: all outputs are at reset values. Pulse `start`: `imem_req`=1 with `imem_addr`=0 on the next cycle.
- Program LDA 3, ADD 4, STA 5, HLT with mem[3]=3 and mem[4]=6: mem[5]=1 (wrap); `halted`=1 after 15 cycles at zero-wait.
- LDA of 4, COM, CSL, SHR: ACC=3, 6, 3. A 3-cycle `dmem_ack` delay lengthens LDA by exactly 3 cycles.
- ACC=4, BAN 7: next fetch address is 7. With ACC=3, BAN 7 falls through to PC+1. JMP from addr 15 to 2 works; sequential fetch from 15 wraps to 0.
- Opcode 0xB: `illegal`=1 and `halted`=1. A subsequent `start` clears `illegal` and refetches at address 0.
- Assert `rst` during MEMRD with `dmem_rd`=1: `dmem_rd` falls in the same cycle and all state returns to reset values.
